// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE handshake, input clamping and optional
// auto-reload of the last loaded value on acknowledge.
module countdown_timer #(
    parameter int MAX_COUNTER_VALUE = 160,
    parameter int AUTO_RELOAD       = 0,
    localparam int W                = $clog2(MAX_COUNTER_VALUE + 1)
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         enable_i,
    input  logic         ack_i,
    output logic         busy_o,
    output logic         finished_o,
    output logic [W-1:0] counter_val_o,
    output logic         range_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX_VAL = W'(MAX_COUNTER_VALUE);

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         range_err_q, range_err_d;

    logic         over_range;
    logic [W-1:0] load_clamped;

    assign over_range   = (load_val_i > MAX_VAL);
    assign load_clamped = over_range ? MAX_VAL : load_val_i;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves one unassigned (no latch).
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        range_err_d = 1'b0;

        if (load_i) begin
            count_d     = load_clamped;
            reload_d    = load_clamped;
            range_err_d = over_range;
            state_d     = (load_clamped != '0) ? RUN : DONE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (enable_i) begin
                        // Guarded so a zero count can never wrap; reaching 0 ends the run.
                        if (count_q > W'(1)) begin
                            count_d = count_q - W'(1);
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        if (AUTO_RELOAD != 0) begin
                            count_d = reload_q;
                            state_d = (reload_q != '0) ? RUN : DONE;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            range_err_q <= range_err_d;
        end
    end

    assign busy_o        = (state_q == RUN);
    assign finished_o    = (state_q == DONE);
    assign counter_val_o = count_q;
    assign range_err_o   = range_err_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MAX_COUNTER_VALUE, default 160; largest value the timer SHALL hold.
REQ-002 Parameter AUTO_RELOAD, default 0; when 1, the timer SHALL restart from the last loaded value on acknowledge.
REQ-003 Local width W SHALL equal $clog2(MAX_COUNTER_VALUE + 1).
REQ-004 clock_i  in  1  single clock; all logic SHALL sample on the rising edge.
REQ-005 reset_i  in  1  reset, synchronous, active-low.
REQ-006 load_i  in  1  load strobe; captures load_val_i.
REQ-007 load_val_i  in  W  start value for the countdown.
REQ-008 enable_i  in  1  count permission; the count is frozen while low.
REQ-009 ack_i  in  1  acknowledge of finished_o.
REQ-010 busy_o  out  1  high in state RUN.
REQ-011 finished_o  out  1  high in state DONE.
REQ-012 counter_val_o  out  W  current remaining count, registered.
REQ-013 range_err_o  out  1  one-cycle pulse when load_val_i > MAX_COUNTER_VALUE.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE, encoded in registers; busy_o and finished_o SHALL decode directly from the state register.
REQ-015 Load behaviour: in any state, load_i=1 at an edge SHALL set counter_val_o to min(load_val_i, MAX_COUNTER_VALUE) and store that value in an internal reload register.
REQ-016 After a load, the state SHALL be RUN if the loaded value is > 0, and DONE if it is 0.
REQ-017 Load priority: load_i SHALL take priority over decrement and over ack_i in the same cycle.
REQ-018 Clamping: if load_val_i > MAX_COUNTER_VALUE, range_err_o SHALL be 1 for exactly the cycle following the load edge, and the value SHALL be clamped.
REQ-019 Counting: in RUN with enable_i=1 and load_i=0, counter_val_o SHALL decrement by 1 per edge.
REQ-020 Counting: in RUN with enable_i=0, counter_val_o and the state SHALL hold.
REQ-021 Terminal count: the edge that decrements 1 to 0 SHALL also move the state to DONE.
  - finished_o rises in the same cycle counter_val_o reads 0 (no extra latency).
  - A load of N with enable held high SHALL therefore reach DONE after exactly N edges.
REQ-022 DONE behaviour: finished_o SHALL stay high until an edge with ack_i=1; enable_i SHALL be ignored in DONE.
REQ-023 Acknowledge, AUTO_RELOAD=0: DONE with ack_i=1 SHALL go to IDLE with counter_val_o=0.
REQ-024 Acknowledge, AUTO_RELOAD=1: DONE with ack_i=1 SHALL reload counter_val_o from the reload register.
  - Next state is RUN if the reload value is > 0.
  - Next state stays DONE if the reload value is 0.
REQ-025 IDLE behaviour: with no load, IDLE SHALL hold counter_val_o and ignore enable_i and ack_i.
REQ-026 ack_i outside DONE SHALL have no effect.
REQ-027 Arithmetic: the counter SHALL never wrap below 0 or exceed MAX_COUNTER_VALUE.

Reset
REQ-028 reset_i=0 at an edge SHALL, in every state, set:
  - state to IDLE;
  - counter_val_o and the reload register to 0;
  - busy_o, finished_o and range_err_o to 0.
REQ-029 Reset SHALL override load_i, enable_i and ack_i in the same cycle.
REQ-030 Reset mid-count SHALL abort the countdown; no finished_o pulse SHALL follow.

Verification
REQ-031 Basic countdown: load 5, enable high -> busy_o=1 with counter_val_o 5,4,3,2,1 on successive cycles; then counter_val_o=0 and finished_o=1 on the 5th edge; ack -> IDLE.
REQ-032 Pause: load 10, enable high 3 edges, low 4 edges, high again -> counter_val_o holds 7 during the pause; finished_o after 10 enabled edges in total.
REQ-033 Clamp and zero load:
  - load 200 (MAX=160) -> counter_val_o=160 and range_err_o pulses one cycle.
  - load 0 -> finished_o=1 and busy_o=0 on the next cycle.
REQ-034 Simultaneous events:
  - load 4 in DONE together with ack_i=1 -> RUN with counter_val_o=4, finished_o=0.
  - load 6 while RUN at value 2 -> restarts at 6.
REQ-035 Auto-reload (AUTO_RELOAD=1): load 3, run to DONE, ack -> counter_val_o=3, busy_o=1; second DONE after 3 more enabled edges.
REQ-036 Reset mid-operation: reset_i=0 for one edge while RUN at value 50 -> all outputs 0 and state IDLE; with enable high, no finished_o for 200 cycles.
